// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: NUM_CH producer lanes in, one merged stream out.
// The slave modport is the mux's view; master is the producers'/consumer's view.
interface stream_mux_rr_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
);
   localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_valid;
   logic                    out_ready;

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/stream_mux_rr.sv
// NUM_CH-to-1 valid/ready stream mux with manual or round-robin selection and a
// registered output stage sustaining one beat per cycle.
module stream_mux_rr #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   stream_mux_rr_if.slave    bus
);
   localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] grant_s;
   logic [SEL_W-1:0]  grant_idx_s;
   logic [WIDTH-1:0]  grant_data_s;
   logic              can_load_s;
   logic              xfer_s;

   logic [SEL_W-1:0]  rr_ptr_r;
   logic [SEL_W-1:0]  rr_ptr_nxt_s;
   logic [WIDTH-1:0]  out_data_r;
   logic [WIDTH-1:0]  out_data_nxt_s;
   logic [SEL_W-1:0]  out_ch_r;
   logic [SEL_W-1:0]  out_ch_nxt_s;
   logic              out_valid_r;
   logic              out_valid_nxt_s;

   // Grant selection: sel-decoded in manual mode, first valid from rr_ptr upward otherwise.
   always_comb begin
      int   idx_s;
      logic hit_s;
      grant_s = '0;
      idx_s   = 0;
      hit_s   = 1'b0;
      if (bus.mode) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx_s          = int'(rr_ptr_r) + k;
            idx_s          = (idx_s >= NUM_CH) ? (idx_s - NUM_CH) : idx_s;
            grant_s[idx_s] = !hit_s && bus.in_valid[idx_s];
            hit_s          = hit_s || bus.in_valid[idx_s];
         end
      end else begin
         // Out-of-range sel matches no channel, so it yields no grant.
         for (int i = 0; i < NUM_CH; i++) begin
            grant_s[i] = (int'(bus.sel) == i) && bus.in_valid[i];
         end
      end
   end

   // Encode the one-hot grant into a channel index and pick that channel's data.
   always_comb begin
      grant_idx_s  = '0;
      grant_data_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant_idx_s  = grant_s[i] ? SEL_W'(i) : grant_idx_s;
         grant_data_s = grant_s[i] ? bus.in_data[i*WIDTH +: WIDTH] : grant_data_s;
      end
   end

   assign can_load_s   = !out_valid_r || bus.out_ready;
   assign xfer_s       = (|grant_s) && can_load_s;
   assign bus.in_ready = grant_s & {NUM_CH{can_load_s}};

   // Next-state for the output register and the round-robin pointer.
   always_comb begin
      out_data_nxt_s  = out_data_r;
      out_ch_nxt_s    = out_ch_r;
      out_valid_nxt_s = out_valid_r;
      rr_ptr_nxt_s    = rr_ptr_r;
      if (xfer_s) begin
         out_data_nxt_s  = grant_data_s;
         out_ch_nxt_s    = grant_idx_s;
         out_valid_nxt_s = 1'b1;
      end else if (out_valid_r && bus.out_ready) begin
         out_valid_nxt_s = 1'b0;
      end else begin
         out_valid_nxt_s = out_valid_r;
      end
      if (xfer_s && bus.mode) begin
         rr_ptr_nxt_s = (int'(grant_idx_s) == NUM_CH - 1) ? '0 : (grant_idx_s + SEL_W'(1));
      end else begin
         rr_ptr_nxt_s = rr_ptr_r;
      end
   end

   // State registers; reset drops any held beat and restores channel 0 priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= '0;
         out_ch_r    <= '0;
         out_valid_r <= 1'b0;
         rr_ptr_r    <= '0;
      end else begin
         out_data_r  <= out_data_nxt_s;
         out_ch_r    <= out_ch_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         rr_ptr_r    <= rr_ptr_nxt_s;
      end
   end

   assign bus.out_data  = out_data_r;
   assign bus.out_ch    = out_ch_r;
   assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (4 channels x 8 bits) with a queue scoreboard of
// expected output beats.
module tb_stream_mux_rr;
   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;

   logic        clk;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  chdat [NUM_CH];
   logic [15:0] sb_q [$];
   logic [15:0] last_beat;

   stream_mux_rr_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

   stream_mux_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
      bus.mode      = m;
      bus.sel       = s;
      bus.in_valid  = v;
      bus.out_ready = ordy;
   endtask

   // One cycle: drive, check in_ready, push expected beat, clock, pop and compare output.
   task automatic step(input string tag, input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic ordy, input logic [3:0] exp_rdy, input int exp_ch,
                       input logic exp_ov);
      drive(m, s, v, ordy);
      #1;
      chk({tag, "/in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
      if (exp_ch >= 0) sb_q.push_back({8'(exp_ch), chdat[exp_ch]});
      @(posedge clk);
      #1;
      chk({tag, "/out_valid"}, 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ch >= 0 && bus.out_valid && sb_q.size() > 0) last_beat = sb_q.pop_front();
      chk({tag, "/out_ch"}, 32'(bus.out_ch), 32'(last_beat[15:8]));
      chk({tag, "/out_data"}, 32'(bus.out_data), 32'(last_beat[7:0]));
   endtask

   initial begin
      chdat[0] = 8'h11;
      chdat[1] = 8'h22;
      chdat[2] = 8'h33;
      chdat[3] = 8'h44;
      last_beat   = 16'h0000;
      rst_n       = 1'b0;
      bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      drive(1'b0, 2'd0, 4'b0000, 1'b1);
      #2;
      chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst/out_data", 32'(bus.out_data), 32'd0);
      chk("rst/out_ch", 32'(bus.out_ch), 32'd0);
      chk("rst/in_ready", 32'(bus.in_ready), 32'd0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Manual select walks sel 0..3
      step("man0", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 0, 1'b1);
      step("man1", 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1, 1'b1);
      step("man2", 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 2, 1'b1);
      step("man3", 1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 3, 1'b1);

      // Round-robin fairness: pointer still 0 since manual transfers leave it alone
      for (int n = 0; n < 8; n++) begin
         step("rr", 1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (n % 4)), n % 4, 1'b1);
      end

      // Sparse requests wrap the pointer from 3 back to 0
      step("sp1a", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1, 1'b1);
      step("sp3a", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 3, 1'b1);
      step("sp1b", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1, 1'b1);
      step("sp3b", 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 3, 1'b1);

      // Back-pressure while 0x22 is held
      step("bp_load", 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1, 1'b1);
      for (int n = 0; n < 3; n++) begin
         step("bp_hold", 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, -1, 1'b1);
      end
      step("bp_release", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 0, 1'b1);

      // Invalid manual select, then idle round-robin
      step("inv_sel", 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, -1, 1'b0);
      step("idle", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, -1, 1'b0);

      // Async reset while 0x33 is held; pointer was 1 before reset
      step("pre_rst", 1'b0, 2'd2, 4'b1111, 1'b0, 4'b0100, 2, 1'b1);
      drive(1'b1, 2'd0, 4'b0000, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst/out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst/out_data", 32'(bus.out_data), 32'd0);
      chk("arst/out_ch", 32'(bus.out_ch), 32'd0);
      last_beat = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst/out_valid", 32'(bus.out_valid), 32'd0);
      step("post_rst0", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 0, 1'b1);
      step("post_rst1", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the 4-to-1 multiplexer: NUM_CH input channels, each WIDTH bits wide, merged onto one registered output stream using valid/ready handshakes.
- Two selection modes:
  - manual: channel chosen by the sel port, same as the combinational mux;
  - round-robin: fair arbitration among the channels that have valid data.
- Sits between multiple producers (e.g. adder result lanes) and a single shared consumer.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- SEL_W, derived localparam = max(1, clog2(NUM_CH)), width of sel and out_ch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- mode  input  1  0 = manual select, 1 = round-robin.
- sel  input  SEL_W  channel index used in manual mode.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async, while rst_n=0):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_ptr=0, so channel 0 has highest priority.
- can_load = !out_valid || out_ready. This gives full throughput of 1 beat/cycle with no bubble.
- Grant (combinational, one-hot or zero, evaluated each cycle):
  - Manual mode (mode=0):
    - grant[sel] = in_valid[sel].
    - sel >= NUM_CH produces no grant.
  - Round-robin mode (mode=1):
    - Scan channels rr_ptr, rr_ptr+1, …, NUM_CH-1, 0, …, rr_ptr-1.
    - Grant the first channel with in_valid=1.
    - No grant if all in_valid=0.
- in_ready[i] = grant[i] && can_load. At most one in_ready bit is high in any cycle.
- Transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - If mode=1, rr_ptr <= (i+1) mod NUM_CH (wrap from NUM_CH-1 to 0).
- Output consumed without a new load (out_valid && out_ready && no transfer): out_valid <= 0; out_data and out_ch hold their values.
- Stall (out_valid && !out_ready):
  - out_data, out_ch and out_valid hold.
  - All in_ready=0.
  - rr_ptr holds.
- Latency: an input beat appears on the output on the clock edge after its transfer (1 cycle).
- rr_ptr update rules:
  - Updates only on round-robin transfers.
  - Manual-mode transfers leave rr_ptr unchanged.
- Mode or sel changes take effect in the same cycle, because grant is combinational. A beat already held in the output register is unaffected.
- Producers may drop in_valid without a handshake. The block takes data only on a transfer.
- Reset asserted mid-stream drops any held beat immediately (out_valid=0 asynchronously). Nothing is replayed after reset is released.
- No combinational path from out_ready to out_data.
- The out_ready → in_ready path is allowed.

Test Plan (NUM_CH=4, WIDTH=8):
- Manual select:
  - Stimulus: mode=0, out_ready=1, in_data ch0..3 = 0x11,0x22,0x33,0x44, all valid; sel steps 0,1,2,3, one per cycle.
  - Required: out_data 0x11,0x22,0x33,0x44 with out_ch 0..3, each 1 cycle after its sel; in_ready is one-hot matching sel.
- Round-robin fairness:
  - Stimulus: mode=1, all four channels held valid for 8 cycles, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0,1,2,3; out_valid stays high continuously from cycle 1.
- Sparse requests / pointer wrap:
  - Stimulus: mode=1, only ch1 and ch3 valid.
  - Required: out_ch sequence 1,3,1,3; after a grant to ch3, rr_ptr returns to 0 and ch1 wins the next grant.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles while the output holds 0x22.
  - Required: out_data stays 0x22, out_valid=1, in_ready=0000 for all 3 cycles; when out_ready=1 the next beat loads on the same edge.
- Invalid select / idle:
  - Stimulus: mode=0, sel=2 with in_valid[2]=0; then all in_valid=0 under mode=1.
  - Required: no transfer, in_ready=0000; out_valid drops to 0 after the pending beat is consumed.
- Async reset mid-operation:
  - Stimulus: assert rst_n=0 between clock edges while out_valid=1 and out_data=0x33.
  - Required: out_valid=0, out_data=0x00, out_ch=0 immediately; after release, the first round-robin grant with all channels valid goes to ch0.
